// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct encodings, ALU operations and pipeline control words.
package pipe_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;

    // Opcodes (instr[31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    // ALU operation encodings seen by the datapath
    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Full decoded control word as it enters ID/EX
    typedef struct packed {
        logic    alu_src;
        logic    reg_dst;
        logic    zero_ext;
        logic    beq;
        logic    bne;
        logic    jump;
        alu_op_e alu_op;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
    } ctrl_t;

    // Control carried into EX/MEM
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } exmem_t;

    // Control carried into MEM/WB
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/funct decoder producing the control word and an illegal flag.
module control_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output ctrl_t               ctrl_o,
    output logic                illegal_o
);

    // Full default to a bubble; each legal encoding sets only its own fields
    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OP_RTYPE: begin
                unique case (funct_i)
                    FN_ADD: ctrl_o.alu_op = ALU_ADD;
                    FN_SUB: ctrl_o.alu_op = ALU_SUB;
                    FN_AND: ctrl_o.alu_op = ALU_AND;
                    FN_OR:  ctrl_o.alu_op = ALU_OR;
                    FN_SLT: ctrl_o.alu_op = ALU_SLT;
                    default: illegal_o = 1'b1;
                endcase
                if (!illegal_o) begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_o.beq    = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_o.bne    = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
            end
            OP_SLTI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_SLT;
            end
            OP_ANDI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.zero_ext  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_AND;
            end
            OP_ORI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.zero_ext  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_OR;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control.sv
// Pipelined main/ALU control: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall detection and branch/jump flush handling.
module pipelined_control
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0]    funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    output logic                  stall_o,
    output logic                  illegal_o,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic                  ex_zero_ext,
    output logic                  ex_beq,
    output logic                  ex_bne,
    output logic                  ex_jump,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write
);

    // ID/EX also keeps rt so a following instruction can be checked for load-use
    typedef struct packed {
        ctrl_t                 ctrl;
        logic [REG_ADDR_W-1:0] rt;
    } idex_t;

    ctrl_t  dec_ctrl;
    logic   dec_illegal;
    logic   hazard_c;
    logic   load_c;

    idex_t  idex_q,    idex_d;
    exmem_t exmem_q,   exmem_d;
    memwb_t memwb_q,   memwb_d;
    logic   illegal_q, illegal_d;

    control_decode u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // Load in EX whose destination feeds the instruction in ID; $0 is not exempted
    assign hazard_c = idex_q.ctrl.mem_read & ((idex_q.rt == id_rs) | (idex_q.rt == id_rt));
    assign stall_o  = HAZARD_EN & id_valid & hazard_c;

    // Next-state for all stage registers; flush/stall/invalid all collapse to a bubble
    always_comb begin
        idex_d    = '0;
        illegal_d = 1'b0;
        exmem_d   = '0;
        memwb_d   = '0;

        load_c = id_valid & ~flush & ~stall_o;
        if (load_c) begin
            idex_d.ctrl = dec_ctrl;
            idex_d.rt   = id_rt;
            illegal_d   = dec_illegal;
        end

        exmem_d.mem_read   = idex_q.ctrl.mem_read;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
        exmem_d.reg_write  = idex_q.ctrl.reg_write;

        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.reg_write  = exmem_q.reg_write;
    end

    // Stage registers; reset drops every in-flight control word at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o     = illegal_q;
    assign ex_alu_src    = idex_q.ctrl.alu_src;
    assign ex_reg_dst    = idex_q.ctrl.reg_dst;
    assign ex_zero_ext   = idex_q.ctrl.zero_ext;
    assign ex_beq        = idex_q.ctrl.beq;
    assign ex_bne        = idex_q.ctrl.bne;
    assign ex_jump       = idex_q.ctrl.jump;
    assign ex_alu_ctrl   = ALU_CTRL_W'(idex_q.ctrl.alu_op);
    assign mem_read      = exmem_q.mem_read;
    assign mem_write     = exmem_q.mem_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_reg_write  = memwb_q.reg_write;

endmodule

// File: tb/tb_pipelined_control.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations, a negedge monitor checks them.
// Two instances share inputs: a (defaults) and b (ALU_CTRL_W=4, HAZARD_EN=0).
module tb_pipelined_control;
    import pipe_ctrl_pkg::*;

    // Observation vector layout: [15] stall [14] illegal [13] alu_src [12] reg_dst
    // [11] zero_ext [10] beq [9] bne [8] jump [7:4] alu_ctrl [3] mem_read
    // [2] mem_write [1] wb_mem_to_reg [0] wb_reg_write
    localparam logic [15:0] M_ST  = 16'h8000;
    localparam logic [15:0] M_EX  = 16'h7FF0;
    localparam logic [15:0] M_MEM = 16'h000C;
    localparam logic [15:0] M_WB  = 16'h0003;
    localparam logic [15:0] M_ALL = 16'hFFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       flush;

    logic       stall_a, illegal_a, alu_src_a, reg_dst_a, zero_ext_a, beq_a, bne_a, jump_a;
    logic [2:0] alu_a;
    logic       mrd_a, mwr_a, m2r_a, rw_a;
    logic       stall_b, illegal_b, alu_src_b, reg_dst_b, zero_ext_b, beq_b, bne_b, jump_b;
    logic [3:0] alu_b;
    logic       mrd_b, mwr_b, m2r_b, rw_b;

    logic [15:0] vec_a, vec_b;

    typedef struct {
        int          cyc;
        bit          b;
        logic [15:0] mask;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] act;

    always #5 clk = ~clk;

    pipelined_control dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
        .stall_o(stall_a), .illegal_o(illegal_a),
        .ex_alu_src(alu_src_a), .ex_reg_dst(reg_dst_a), .ex_zero_ext(zero_ext_a),
        .ex_beq(beq_a), .ex_bne(bne_a), .ex_jump(jump_a), .ex_alu_ctrl(alu_a),
        .mem_read(mrd_a), .mem_write(mwr_a),
        .wb_mem_to_reg(m2r_a), .wb_reg_write(rw_a)
    );

    pipelined_control #(.ALU_CTRL_W(4), .REG_ADDR_W(5), .HAZARD_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
        .stall_o(stall_b), .illegal_o(illegal_b),
        .ex_alu_src(alu_src_b), .ex_reg_dst(reg_dst_b), .ex_zero_ext(zero_ext_b),
        .ex_beq(beq_b), .ex_bne(bne_b), .ex_jump(jump_b), .ex_alu_ctrl(alu_b),
        .mem_read(mrd_b), .mem_write(mwr_b),
        .wb_mem_to_reg(m2r_b), .wb_reg_write(rw_b)
    );

    assign vec_a = {stall_a, illegal_a, alu_src_a, reg_dst_a, zero_ext_a, beq_a, bne_a, jump_a,
                    1'b0, alu_a, mrd_a, mwr_a, m2r_a, rw_a};
    assign vec_b = {stall_b, illegal_b, alu_src_b, reg_dst_b, zero_ext_b, beq_b, bne_b, jump_b,
                    alu_b, mrd_b, mwr_b, m2r_b, rw_b};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation due this cycle is compared and retired
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = sb[i].b ? vec_b : vec_a;
                n_chk++;
                if ((act & sb[i].mask) === (sb[i].val & sb[i].mask))
                    n_pass++;
                else
                    $display("FAIL %s dut_%s cycle %0d: got %h expected %h (mask %h)",
                             sb[i].name, sb[i].b ? "b" : "a", cyc,
                             act & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int at, input bit b, input logic [15:0] m,
                        input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = at; e.b = b; e.mask = m; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input bit fl);
        id_valid = v; opcode = op; funct = fn; id_rs = rs; id_rt = rt; flush = fl;
    endtask

    // Present one ID-stage instruction for a cycle and register its expected trail
    task automatic issue(input bit v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input bit fl,
                         input bit st, input logic [15:0] ex, input logic [15:0] mem,
                         input logic [15:0] wb, input bit bsame, input string nm);
        drive(v, op, fn, rs, rt, fl);
        push(cyc,     1'b0, M_ST,  {st, 15'h0}, {nm, ".stall"});
        push(cyc + 1, 1'b0, M_EX,  ex,          {nm, ".ex"});
        push(cyc + 2, 1'b0, M_MEM, mem,         {nm, ".mem"});
        push(cyc + 3, 1'b0, M_WB,  wb,          {nm, ".wb"});
        if (bsame) begin
            push(cyc,     1'b1, M_ST,  16'h0, {nm, ".stall"});
            push(cyc + 1, 1'b1, M_EX,  ex,    {nm, ".ex"});
            push(cyc + 2, 1'b1, M_MEM, mem,   {nm, ".mem"});
            push(cyc + 3, 1'b1, M_WB,  wb,    {nm, ".wb"});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            issue(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, "idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        push(cyc, 1'b0, M_ALL, 16'h0, "reset.hold");
        push(cyc, 1'b1, M_ALL, 16'h0, "reset.hold");
        @(posedge clk); #1;
        rst = 1'b0;
        push(cyc, 1'b0, M_ALL, 16'h0, "reset.release");
        push(cyc, 1'b1, M_ALL, 16'h0, "reset.release");
        idle(2);

        // Mid-stream reset: lw reaches EX/MEM, add in ID/EX, then rst strikes
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd8, 1'b0);
        push(cyc + 1, 1'b0, M_EX, 16'h2020, "rst.lw_ex");
        push(cyc + 1, 1'b1, M_EX, 16'h2020, "rst.lw_ex");
        @(posedge clk); #1;
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd2, 5'd3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        push(cyc, 1'b0, M_ALL, 16'h0, "rst.async_clear");
        push(cyc, 1'b1, M_ALL, 16'h0, "rst.async_clear");
        #1;
        n_chk++;
        if (vec_a === 16'h0) n_pass++;
        else $display("FAIL rst.direct dut_a: got %h expected 0000", vec_a);
        n_chk++;
        if (vec_b === 16'h0) n_pass++;
        else $display("FAIL rst.direct dut_b: got %h expected 0000", vec_b);
        @(posedge clk); #1;
        rst = 1'b0;
        push(cyc,     1'b0, M_ALL, 16'h0, "rst.released");
        push(cyc,     1'b1, M_ALL, 16'h0, "rst.released");
        push(cyc + 1, 1'b0, M_ALL, 16'h0, "rst.after_release");
        push(cyc + 1, 1'b1, M_ALL, 16'h0, "rst.after_release");
        n_chk++;
        if ({mrd_a, mwr_a, m2r_a, rw_a} === 4'b0000) n_pass++;
        else $display("FAIL rst.direct_release dut_a: mem/wb not cleared");
        n_chk++;
        if ({mrd_b, mwr_b, m2r_b, rw_b} === 4'b0000) n_pass++;
        else $display("FAIL rst.direct_release dut_b: mem/wb not cleared");
        idle(3);

        // add, lw, sw back to back
        issue(1, OP_RTYPE, FN_ADD, 5'd1, 5'd2, 0, 0, 16'h1020, 16'h0000, 16'h0001, 1, "str.add");
        issue(1, OP_LW,    6'h00,  5'd3, 5'd4, 0, 0, 16'h2020, 16'h0008, 16'h0003, 1, "str.lw");
        issue(1, OP_SW,    6'h00,  5'd6, 5'd7, 0, 0, 16'h2020, 16'h0004, 16'h0000, 1, "str.sw");
        idle(2);

        // Remaining R-type functs and other opcodes
        issue(1, OP_RTYPE, FN_SUB, 5'd1, 5'd2, 0, 0, 16'h1060, 16'h0, 16'h0001, 1, "dec.sub");
        issue(1, OP_RTYPE, FN_AND, 5'd1, 5'd2, 0, 0, 16'h1000, 16'h0, 16'h0001, 1, "dec.and");
        issue(1, OP_RTYPE, FN_OR,  5'd1, 5'd2, 0, 0, 16'h1010, 16'h0, 16'h0001, 1, "dec.or");
        issue(1, OP_RTYPE, FN_SLT, 5'd1, 5'd2, 0, 0, 16'h1070, 16'h0, 16'h0001, 1, "dec.slt");
        issue(1, OP_BNE,   6'h00,  5'd1, 5'd2, 0, 0, 16'h0260, 16'h0, 16'h0000, 1, "dec.bne");
        issue(1, OP_J,     6'h00,  5'd0, 5'd0, 0, 0, 16'h0100, 16'h0, 16'h0000, 1, "dec.j");
        issue(1, OP_ADDI,  6'h00,  5'd1, 5'd2, 0, 0, 16'h2020, 16'h0, 16'h0001, 1, "dec.addi");
        idle(2);

        // Load-use on rs: a stalls one cycle, b has no hazard logic and proceeds
        issue(1, OP_LW, 6'h00, 5'd1, 5'd5, 0, 0, 16'h2020, 16'h0008, 16'h0003, 1, "hz.lw");
        push(cyc,     1'b1, M_ST, 16'h0,    "hzb.add.stall");
        push(cyc + 1, 1'b1, M_EX, 16'h1020, "hzb.add.ex");
        push(cyc + 3, 1'b1, M_WB, 16'h0001, "hzb.add.wb");
        issue(1, OP_RTYPE, FN_ADD, 5'd5, 5'd2, 0, 1, 16'h0000, 16'h0, 16'h0000, 0, "hz.add_stall");
        issue(1, OP_RTYPE, FN_ADD, 5'd5, 5'd2, 0, 0, 16'h1020, 16'h0, 16'h0001, 1, "hz.add_redo");
        idle(2);

        // Load to $0 followed by a reader of $0 still stalls
        issue(1, OP_LW, 6'h00, 5'd2, 5'd0, 0, 0, 16'h2020, 16'h0008, 16'h0003, 1, "hz0.lw");
        push(cyc,     1'b1, M_ST, 16'h0,    "hz0b.addi.stall");
        push(cyc + 1, 1'b1, M_EX, 16'h2020, "hz0b.addi.ex");
        push(cyc + 3, 1'b1, M_WB, 16'h0001, "hz0b.addi.wb");
        issue(1, OP_ADDI, 6'h00, 5'd0, 5'd9, 0, 1, 16'h0000, 16'h0, 16'h0000, 0, "hz0.addi_stall");
        issue(1, OP_ADDI, 6'h00, 5'd0, 5'd9, 0, 0, 16'h2020, 16'h0, 16'h0001, 1, "hz0.addi_redo");
        idle(2);

        // beq in EX, flush squashes ori in ID
        issue(1, OP_BEQ, 6'h00, 5'd1, 5'd2, 0, 0, 16'h0460, 16'h0, 16'h0, 1, "fl.beq");
        issue(1, OP_ORI, 6'h00, 5'd3, 5'd4, 1, 0, 16'h0000, 16'h0, 16'h0, 1, "fl.ori_flushed");
        idle(1);
        // flush together with a load-use hazard on rt: one bubble, stall still visible
        issue(1, OP_LW,  6'h00, 5'd1, 5'd5, 0, 0, 16'h2020, 16'h0008, 16'h0003, 1, "fs.lw");
        issue(1, OP_ORI, 6'h00, 5'd3, 5'd5, 1, 1, 16'h0000, 16'h0, 16'h0000, 1, "fs.ori_flush_stall");
        issue(1, OP_ORI, 6'h00, 5'd3, 5'd5, 0, 0, 16'h2810, 16'h0, 16'h0001, 1, "fs.ori");
        idle(2);

        // Illegal encodings: one pulse each, none when invalid or flushed
        issue(1, 6'h3F,    6'h00, 5'd0, 5'd0, 0, 0, 16'h4000, 16'h0, 16'h0, 1, "ill.op3f");
        idle(1);
        issue(1, OP_RTYPE, 6'h03, 5'd0, 5'd0, 0, 0, 16'h4000, 16'h0, 16'h0, 1, "ill.fn03");
        idle(1);
        issue(0, 6'h3F,    6'h00, 5'd0, 5'd0, 0, 0, 16'h0000, 16'h0, 16'h0, 1, "ill.op3f_novalid");
        issue(0, OP_RTYPE, 6'h03, 5'd0, 5'd0, 0, 0, 16'h0000, 16'h0, 16'h0, 1, "ill.fn03_novalid");
        issue(1, 6'h3F,    6'h00, 5'd0, 5'd0, 1, 0, 16'h0000, 16'h0, 16'h0, 1, "ill.op3f_flushed");
        idle(1);

        // Immediate logic ops; b shows the zero-filled 4-bit ALU control
        issue(1, OP_ANDI, 6'h00, 5'd1, 5'd2, 0, 0, 16'h2800, 16'h0, 16'h0001, 1, "imm.andi");
        n_chk++;
        if ((alu_b === 4'b0000) && (zero_ext_b === 1'b1)) n_pass++;
        else $display("FAIL imm.andi.direct dut_b: alu %b zero_ext %b", alu_b, zero_ext_b);
        issue(1, OP_SLTI, 6'h00, 5'd1, 5'd2, 0, 0, 16'h2070, 16'h0, 16'h0001, 1, "imm.slti");
        n_chk++;
        if ((alu_b === 4'b0111) && (zero_ext_b === 1'b0)) n_pass++;
        else $display("FAIL imm.slti.direct dut_b: alu %b zero_ext %b", alu_b, zero_ext_b);
        idle(1);

        repeat (4) @(posedge clk);
        #1;
        foreach (sb[i]) begin
            n_chk++;
            $display("FAIL %s dut_%s never checked (due cycle %0d)",
                     sb[i].name, sb[i].b ? "b" : "a", sb[i].cyc);
        end
        if (n_pass != n_chk)
            $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
